// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encoding,
// bubble word and instruction memory size.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  // Kept in one place so instructionMemory and fetch agree on the size.
  localparam int unsigned MEM_BYTES = 16384;
  localparam logic [31:0] NOP_WORD  = 32'h0000_0000;

endpackage : fetch_pkg

// File: rtl/instruction_fetch_if.sv
// Signal bundle between the fetch stage and its environment: start/redirect
// control, the instruction memory port and the IF/ID register outputs.
interface instruction_fetch_if;

  logic        start;
  logic [31:0] start_pc;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] PC;
  logic [31:0] instruction;
  logic [31:0] if_id_instruction;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic        fetch_fault;
  logic [31:0] fetch_count;

  // Fetch stage side.
  modport master (
    input  start, start_pc, stall, redirect_valid, redirect_target, instruction,
    output PC, if_id_instruction, if_id_pc4, if_id_valid, fetch_fault, fetch_count
  );

  // Environment side: control sources, instruction memory, decode.
  modport slave (
    output start, start_pc, stall, redirect_valid, redirect_target, instruction,
    input  PC, if_id_instruction, if_id_pc4, if_id_valid, fetch_fault, fetch_count
  );

endinterface : instruction_fetch_if

// File: rtl/fetch_addr_check.sv
// Combinational PC legality check: word aligned and within the memory.
// The address is taken 33 bits wide so an incremented PC that carries out
// of 32 bits is seen as out of range instead of wrapping to zero.
module fetch_addr_check #(
  parameter int unsigned MEM_BYTES = fetch_pkg::MEM_BYTES
) (
  input  logic [32:0] addr,
  output logic        legal
);

  localparam logic [32:0] LAST_WORD = 33'(MEM_BYTES - 4);

  // Aligned and not beyond the last word of memory.
  always_comb begin
    legal = (addr[1:0] == 2'b00) && (addr <= LAST_WORD);
  end

endmodule : fetch_addr_check

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC register, IDLE/RUN/HALT control, IF/ID
// pipeline register and a count of delivered instructions.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter int unsigned MEM_BYTES = fetch_pkg::MEM_BYTES
) (
  input logic                 clk,
  input logic                 rst,
  instruction_fetch_if.master bus
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  if_id_instruction_q, if_id_instruction_d;
  logic [31:0]  if_id_pc4_q, if_id_pc4_d;
  logic         if_id_valid_q, if_id_valid_d;
  logic         fetch_fault_q, fetch_fault_d;
  logic [31:0]  fetch_count_q, fetch_count_d;

  logic [31:0] pc_plus4;
  logic [32:0] pc_plus4_wide;
  logic [32:0] target_wide;
  logic        target_legal;
  logic        pc_plus4_legal;

  // Only IDLE consumes start_pc and only RUN consumes redirect_target,
  // so one checker serves both.
  always_comb begin
    target_wide = (state_q == IDLE) ? {1'b0, bus.start_pc}
                                    : {1'b0, bus.redirect_target};
  end

  // Sequential-PC arithmetic; the wide copy feeds the range check.
  always_comb begin
    pc_plus4      = pc_q + 32'd4;
    pc_plus4_wide = {1'b0, pc_q} + 33'd4;
  end

  fetch_addr_check #(.MEM_BYTES(MEM_BYTES)) u_target_check (
    .addr  (target_wide),
    .legal (target_legal)
  );

  fetch_addr_check #(.MEM_BYTES(MEM_BYTES)) u_pc4_check (
    .addr  (pc_plus4_wide),
    .legal (pc_plus4_legal)
  );

  // Next-state, PC and IF/ID selection; redirect beats stall beats advance.
  always_comb begin
    // NOTE: every _d gets its hold value first so no path leaves a signal
    // unassigned, which would otherwise infer a latch.
    state_d             = state_q;
    pc_d                = pc_q;
    if_id_instruction_d = if_id_instruction_q;
    if_id_pc4_d         = if_id_pc4_q;
    if_id_valid_d       = if_id_valid_q;
    fetch_fault_d       = fetch_fault_q;
    fetch_count_d       = fetch_count_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (target_legal) begin
            pc_d    = bus.start_pc;
            state_d = RUN;
          end else begin
            fetch_fault_d = 1'b1;
            state_d       = HALT;
          end
        end
      end

      RUN: begin
        if (bus.redirect_valid) begin
          if_id_instruction_d = NOP_WORD;
          if_id_pc4_d         = 32'd0;
          if_id_valid_d       = 1'b0;
          if (target_legal) begin
            pc_d = bus.redirect_target;
          end else begin
            fetch_fault_d = 1'b1;
            state_d       = HALT;
          end
        end else if (!bus.stall) begin
          if_id_instruction_d = bus.instruction;
          if_id_pc4_d         = pc_plus4;
          if_id_valid_d       = 1'b1;
          fetch_count_d       = fetch_count_q + 32'd1;
          if (pc_plus4_legal) begin
            pc_d = pc_plus4;
          end else begin
            // The word at the last address is still delivered above.
            fetch_fault_d = 1'b1;
            state_d       = HALT;
          end
        end
      end

      HALT: begin
        // Flush once on entry; reloading the bubble afterwards is a hold.
        if_id_instruction_d = NOP_WORD;
        if_id_pc4_d         = 32'd0;
        if_id_valid_d       = 1'b0;
      end

      default: state_d = IDLE;
    endcase
  end

  // State, PC, IF/ID and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the
    // pre-edge values regardless of statement order.
    if (rst) begin
      state_q             <= IDLE;
      pc_q                <= 32'd0;
      if_id_instruction_q <= NOP_WORD;
      if_id_pc4_q         <= 32'd0;
      if_id_valid_q       <= 1'b0;
      fetch_fault_q       <= 1'b0;
      fetch_count_q       <= 32'd0;
    end else begin
      state_q             <= state_d;
      pc_q                <= pc_d;
      if_id_instruction_q <= if_id_instruction_d;
      if_id_pc4_q         <= if_id_pc4_d;
      if_id_valid_q       <= if_id_valid_d;
      fetch_fault_q       <= fetch_fault_d;
      fetch_count_q       <= fetch_count_d;
    end
  end

  assign bus.PC                = pc_q;
  assign bus.if_id_instruction = if_id_instruction_q;
  assign bus.if_id_pc4         = if_id_pc4_q;
  assign bus.if_id_valid       = if_id_valid_q;
  assign bus.fetch_fault       = fetch_fault_q;
  assign bus.fetch_count       = fetch_count_q;

endmodule : instruction_fetch

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a small word-addressed
// instruction memory model holding the test program words.
module tb_instruction_fetch;
  import fetch_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  instruction_fetch_if fif ();

  instruction_fetch dut (
    .clk (clk),
    .rst (rst),
    .bus (fif)
  );

  always #5 clk = ~clk;

  // Known program words; every other address returns a tagged filler.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'd100: return 32'h4808_0000;
      32'd104: return 32'h4809_0004;
      32'd200: return 32'h2413_0005;
      32'd600: return 32'h2413_000f;
      32'd604: return 32'h2414_000a;
      default: return 32'hC000_0000 | a;
    endcase
  endfunction

  assign fif.instruction = mem_word(fif.PC);

  // Advance one edge, then settle away from it before driving or sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    fif.start           = 1'b0;
    fif.start_pc        = 32'd0;
    fif.stall           = 1'b0;
    fif.redirect_valid  = 1'b0;
    fif.redirect_target = 32'd0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic do_start(input logic [31:0] pc);
    fif.start    = 1'b1;
    fif.start_pc = pc;
    tick();
    fif.start    = 1'b0;
  endtask

  task automatic expect_ifid(input string tag, input logic [31:0] ins,
                             input logic [31:0] pc4, input logic vld);
    total++;
    if (fif.if_id_instruction !== ins || fif.if_id_pc4 !== pc4 || fif.if_id_valid !== vld) begin
      bad++;
      $display("FAIL %s ifid: got ins=%h pc4=%0d v=%b want ins=%h pc4=%0d v=%b", tag,
               fif.if_id_instruction, fif.if_id_pc4, fif.if_id_valid, ins, pc4, vld);
    end
  endtask

  task automatic expect_ctl(input string tag, input logic [31:0] pc,
                            input logic fault, input logic [31:0] cnt);
    total++;
    if (fif.PC !== pc || fif.fetch_fault !== fault || fif.fetch_count !== cnt) begin
      bad++;
      $display("FAIL %s ctl: got pc=%0d fault=%b cnt=%0d want pc=%0d fault=%b cnt=%0d", tag,
               fif.PC, fif.fetch_fault, fif.fetch_count, pc, fault, cnt);
    end
  endtask

  task automatic expect_state(input string tag, input fetch_state_e st);
    total++;
    if (dut.state_q !== st) begin
      bad++;
      $display("FAIL %s state: got %0d want %0d", tag, dut.state_q, st);
    end
  endtask

  task automatic test_reset();
    do_reset();
    expect_ifid("reset", NOP_WORD, 32'd0, 1'b0);
    expect_ctl("reset", 32'd0, 1'b0, 32'd0);
    expect_state("reset", IDLE);
    // Stall and redirect are ignored in IDLE.
    fif.stall = 1'b1; fif.redirect_valid = 1'b1; fif.redirect_target = 32'd600;
    tick();
    idle_inputs();
    expect_ctl("idle_ignore", 32'd0, 1'b0, 32'd0);
    expect_state("idle_ignore", IDLE);
  endtask

  task automatic test_basic_fetch();
    do_reset();
    do_start(32'd100);
    expect_ctl("start", 32'd100, 1'b0, 32'd0);
    expect_ifid("start", NOP_WORD, 32'd0, 1'b0);
    tick();
    expect_ifid("fetch0", 32'h4808_0000, 32'd104, 1'b1);
    expect_ctl("fetch0", 32'd104, 1'b0, 32'd1);
    tick();
    expect_ifid("fetch1", 32'h4809_0004, 32'd108, 1'b1);
    expect_ctl("fetch1", 32'd108, 1'b0, 32'd2);
    // start is ignored while running.
    fif.start = 1'b1; fif.start_pc = 32'd600;
    tick();
    fif.start = 1'b0;
    expect_ifid("run_start", 32'hC000_006C, 32'd112, 1'b1);
    expect_ctl("run_start", 32'd112, 1'b0, 32'd3);
  endtask

  task automatic test_stall();
    do_reset();
    do_start(32'd600);
    tick();
    expect_ifid("pre_stall", 32'h2413_000f, 32'd604, 1'b1);
    fif.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_ifid("stall", 32'h2413_000f, 32'd604, 1'b1);
      expect_ctl("stall", 32'd604, 1'b0, 32'd1);
    end
    fif.stall = 1'b0;
    tick();
    expect_ifid("post_stall", 32'h2414_000a, 32'd608, 1'b1);
    expect_ctl("post_stall", 32'd608, 1'b0, 32'd2);
  endtask

  task automatic test_redirect();
    do_reset();
    do_start(32'd100);
    tick();
    fif.redirect_valid = 1'b1; fif.redirect_target = 32'd600;
    tick();
    fif.redirect_valid = 1'b0;
    expect_ifid("redir_bubble", NOP_WORD, 32'd0, 1'b0);
    expect_ctl("redir_bubble", 32'd600, 1'b0, 32'd1);
    tick();
    expect_ifid("redir_target", 32'h2413_000f, 32'd604, 1'b1);
    expect_ctl("redir_target", 32'd604, 1'b0, 32'd2);
    // Redirect and stall together: redirect wins.
    fif.redirect_valid = 1'b1; fif.redirect_target = 32'd100; fif.stall = 1'b1;
    tick();
    fif.redirect_valid = 1'b0; fif.stall = 1'b0;
    expect_ifid("redir_stall", NOP_WORD, 32'd0, 1'b0);
    expect_ctl("redir_stall", 32'd100, 1'b0, 32'd2);
    tick();
    expect_ifid("redir_stall_tgt", 32'h4808_0000, 32'd104, 1'b1);
    expect_ctl("redir_stall_tgt", 32'd104, 1'b0, 32'd3);
  endtask

  task automatic test_illegal_targets();
    // Misaligned redirect from a running program.
    do_reset();
    do_start(32'd100);
    tick();
    fif.redirect_valid = 1'b1; fif.redirect_target = 32'd602;
    tick();
    fif.redirect_valid = 1'b0;
    expect_ifid("redir602", NOP_WORD, 32'd0, 1'b0);
    expect_ctl("redir602", 32'd104, 1'b1, 32'd1);
    expect_state("redir602", HALT);
    fif.start = 1'b1; fif.start_pc = 32'd100;
    tick();
    fif.start = 1'b0;
    expect_ctl("halt_hold", 32'd104, 1'b1, 32'd1);
    expect_ifid("halt_hold", NOP_WORD, 32'd0, 1'b0);
    // Out-of-range start address.
    do_reset();
    do_start(32'd16384);
    expect_ctl("start16384", 32'd0, 1'b1, 32'd0);
    expect_state("start16384", HALT);
    tick();
    expect_ifid("start16384", NOP_WORD, 32'd0, 1'b0);
    expect_ctl("start16384_b", 32'd0, 1'b1, 32'd0);
    // Redirect to the top of the 32-bit space must not look legal.
    do_reset();
    do_start(32'd100);
    fif.redirect_valid = 1'b1; fif.redirect_target = 32'hFFFF_FFFC;
    tick();
    fif.redirect_valid = 1'b0;
    expect_ctl("redir_top", 32'd100, 1'b1, 32'd0);
  endtask

  task automatic test_end_of_memory();
    do_reset();
    do_start(32'd16380);
    expect_ctl("eom_start", 32'd16380, 1'b0, 32'd0);
    tick();
    expect_ifid("eom_last", 32'hC000_3FFC, 32'd16384, 1'b1);
    expect_ctl("eom_last", 32'd16380, 1'b1, 32'd1);
    expect_state("eom_last", HALT);
    tick();
    expect_ifid("eom_bubble", NOP_WORD, 32'd0, 1'b0);
    expect_ctl("eom_bubble", 32'd16380, 1'b1, 32'd1);
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    do_start(32'd600);
    tick();
    fif.stall = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    fif.stall = 1'b0;
    expect_ifid("mid_rst", NOP_WORD, 32'd0, 1'b0);
    expect_ctl("mid_rst", 32'd0, 1'b0, 32'd0);
    expect_state("mid_rst", IDLE);
    do_start(32'd200);
    tick();
    expect_ifid("restart", 32'h2413_0005, 32'd204, 1'b1);
    expect_ctl("restart", 32'd204, 1'b0, 32'd1);
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    test_reset();
    test_basic_fetch();
    test_stall();
    test_redirect();
    test_illegal_targets();
    test_end_of_memory();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_instruction_fetch

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction fetch stage of the pipelined MIPS core: owns the program counter, drives the byte address into `instructionMemory`, and captures the returned big-endian word into the IF/ID pipeline register. A start handshake selects the program entry point, so one memory image can hold several test programs. Redirects from later stages, such as a taken branch, load a new PC. Out-of-range and misaligned addresses halt fetch with a sticky fault.

## Interface
- `MEM_BYTES`, 16384: instruction memory size in bytes; legal PC range is 0..MEM_BYTES-4.
- `NOP_WORD`, 32'h00000000: bubble word written into IF/ID on a flush or halt.

- `clk`  in  1  rising-edge clock, the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse that begins fetching at `start_pc`; honoured only in IDLE.
- `start_pc`  in  32  entry byte address.
- `stall`  in  1  hazard stall from decode; PC and IF/ID hold.
- `redirect_valid`  in  1  load `redirect_target` and flush IF/ID.
- `redirect_target`  in  32  new byte address.
- `PC`  out  32  byte address to `instructionMemory.PC`.
- `instruction`  in  32  word from `instructionMemory`; combinational from `PC` in the same cycle.
- `if_id_instruction`  out  32  IF/ID instruction register.
- `if_id_pc4`  out  32  IF/ID PC+4.
- `if_id_valid`  out  1  IF/ID holds a real instruction.
- `fetch_fault`  out  1  sticky flag: a bad address was seen; cleared only by `rst`.
- `fetch_count`  out  32  number of valid IF/ID loads since reset; wraps modulo 2^32.

## Operation
- **States:** IDLE, RUN, HALT.
- **Reset:** state IDLE; `PC`=0; `if_id_instruction`=NOP_WORD; `if_id_pc4`=0; `if_id_valid`=0; `fetch_fault`=0; `fetch_count`=0.
- **A PC value is legal** when `addr[1:0]==0` and `addr <= MEM_BYTES-4`.
- **IDLE:**
  - `stall` and `redirect_valid` are ignored; IF/ID holds the bubble.
  - `start` with a legal `start_pc`: `PC`<=start_pc, go to RUN.
  - `start` with an illegal `start_pc`: `fetch_fault`<=1, go to HALT.
- **RUN, evaluated in this priority order each edge:**
  1. `redirect_valid`:
     - IF/ID <= {NOP_WORD, 0, valid 0}.
     - Legal target: `PC`<=target.
     - Illegal target: `PC` holds, `fetch_fault`<=1, go to HALT.
  2. `stall`: `PC`, IF/ID and `fetch_count` all hold.
  3. Otherwise, advance:
     - IF/ID <= {instruction, PC+4, valid 1}; `fetch_count`++.
     - If PC+4 is legal: `PC`<=PC+4.
     - Else: `PC` holds, `fetch_fault`<=1, go to HALT. The last word is still delivered.
- **RUN ignores `start`.**
- **HALT:**
  - IF/ID <= bubble on the first HALT edge, then holds.
  - `PC` holds.
  - All inputs except `rst` are ignored.
- **Arithmetic:** PC+4 is computed 32-bit unsigned. The range check uses a 33-bit compare, so 32'hFFFFFFFC+4 is flagged illegal and does not wrap.

## Timing
- `PC` is a register output. `instruction` is valid in the same cycle and sampled at the next rising edge.
- **Start:** `start` sampled at edge N, so `PC`=start_pc after N. The first valid `if_id_instruction` appears after edge N+1.
- **Throughput:** one instruction per cycle when unstalled.
- **Redirect at edge N:**
  - Bubble in IF/ID after edge N.
  - `PC`=target after edge N.
  - The target's word is in IF/ID after edge N+1.
  - Redirect penalty is exactly one bubble.
- **Stall held for k cycles:** IF/ID is unchanged for k cycles, and no instruction is lost or duplicated.
- **`fetch_fault`** rises on the same edge that enters HALT.
- **`rst`** overrides everything on the edge it is sampled, including mid-redirect and mid-stall.

## Structure
- Shared package `fetch_pkg`:
  - State encoding: IDLE=2'd0, RUN=2'd1, HALT=2'd2.
  - `NOP_WORD` default.
  - `MEM_BYTES` default, kept shared with `instructionMemory` sizing.
- One sub-module, `fetch_addr_check`: combinational legality check (alignment and range) taking `MEM_BYTES`. It is instantiated twice: once for the start/redirect target, once for PC+4.
- FSM, PC register, IF/ID register and counter all live in `instruction_fetch`.

## Test plan
- **Basic fetch:** memory loaded with the load test program at byte 100; `start`, start_pc=100.
  - After 2 edges: `if_id_instruction`=32'h48080000, `if_id_pc4`=104.
  - Next edge: 32'h48090004.
  - `fetch_count` increments by 1 per edge.
- **Stall:** running from 600; hold `stall` 3 cycles while IF/ID=32'h2413000f.
  - IF/ID and `PC`=604 are held for 3 cycles.
  - Then 32'h2414000a; `fetch_count` is unaffected by the stall.
- **Redirect:** running from 100, `redirect_valid` with target 600.
  - One bubble (`if_id_valid`=0, instruction 0).
  - Then 32'h2413000f with `if_id_pc4`=604.
  - Also `redirect_valid`+`stall` asserted together: the redirect wins.
- **Illegal targets:**
  - Redirect to 602: `fetch_fault`=1, state HALT, `PC` held, IF/ID bubble.
  - `start_pc`=16384: `fetch_fault`=1, no valid fetch.
- **End of memory:** start_pc=16380.
  - Exactly one valid fetch, with `if_id_pc4`=16384.
  - Then HALT with `fetch_fault`=1 and `fetch_count`=1.
- **Reset mid-run:** assert `rst` in RUN during a stall.
  - All outputs return to their reset values and state is IDLE.
  - A second `start` at 200 fetches 32'h24130005.
